// File: rtl/project_controller.sv
// Control FSM for the 16-bit seed/mix datapath: loads seed and count, then emits
// one chained sample per count step over a valid/ready output stage.
module project_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] seed_in,
  input  logic [15:0] count_in,
  output logic        busy,
  output logic [15:0] bus_data,
  output logic        lda,
  output logic        ldb,
  output logic        decb,
  input  logic        eq,
  input  logic [15:0] z,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CHECK,
    S_EMIT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] seed_q;
  logic [15:0] cnt_q;
  logic [15:0] out_data_reg;
  logic        out_valid_reg;

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      seed_q        <= 16'h0000;
      cnt_q         <= 16'h0000;
      out_data_reg  <= 16'h0000;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && start) begin
        seed_q <= seed_in;
        cnt_q  <= count_in;
      end
      // The output stage is only written in EMIT and only released by a handshake in WAIT.
      if (state_reg == S_EMIT) begin
        out_data_reg  <= z;
        out_valid_reg <= 1'b1;
      end else if (state_reg == S_WAIT && out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    bus_data   = 16'h0000;
    lda        = 1'b0;
    ldb        = 1'b0;
    decb       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        bus_data   = seed_q;
        lda        = 1'b1;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        bus_data   = cnt_q;
        ldb        = 1'b1;
        state_next = S_CHECK;
      end
      S_CHECK: begin
        state_next = eq ? S_DONE : S_EMIT;
      end
      S_EMIT: begin
        // Feed the result straight back as the next seed while counting down.
        bus_data   = z;
        lda        = 1'b1;
        decb       = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (out_valid_reg && out_ready) state_next = S_CHECK;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_project_controller.sv
// Directed bench for project_controller with a behavioural seed/counter datapath;
// table-driven runs plus a hand-written mid-run reset sequence.
module tb_project_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed_in = 16'h0000;
  logic [15:0] count_in = 16'h0000;
  logic        busy;
  logic [15:0] bus_data;
  logic        lda, ldb, decb;
  logic        eq;
  logic [15:0] z;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] last_beat = 16'h0000;

  always #5 clk = ~clk;

  project_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed_in(seed_in), .count_in(count_in),
    .busy(busy), .bus_data(bus_data), .lda(lda), .ldb(ldb), .decb(decb),
    .eq(eq), .z(z), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .done(done)
  );

  function automatic logic [15:0] mix(input logic [15:0] s);
    return {s[14:0], ~(s[15] ^ s[13] ^ s[12] ^ s[10])};
  endfunction

  // Datapath: seed register, down-counter, zero flag, combinational mix.
  logic [15:0] dp_seed, dp_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_seed <= 16'h0000;
      dp_cnt  <= 16'h0000;
    end else begin
      if (lda) dp_seed <= bus_data;
      if (ldb) dp_cnt <= bus_data;
      else if (decb) dp_cnt <= dp_cnt - 16'd1;
    end
  end
  assign eq = (dp_cnt == 16'h0000);
  assign z  = mix(dp_seed);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [15:0] count;
    int          lo_start;
    int          lo_len;
    bit          poke;
    int          exp_done;
    int          exp_beats;
  } vec_t;

  vec_t vecs[6];

  // Entered and left on a negedge; the start edge follows the first negedge.
  task automatic run(input vec_t v, input int idx);
    int beats;
    int decbs;
    bit seen_done;
    logic [15:0] expv;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("hold_out_data", out_data, last_beat);
    start = 1'b1; seed_in = v.seed; count_in = v.count; out_ready = 1'b1;
    expv = mix(v.seed); beats = 0; decbs = 0; seen_done = 0;
    for (int cyc = 1; cyc <= 200 && !seen_done; cyc++) begin
      @(negedge clk);
      start     = v.poke && (cyc == 2 || cyc == 5);
      seed_in   = start ? 16'hDEAD : 16'h0000;
      count_in  = start ? 16'h0007 : 16'h0000;
      out_ready = !(cyc >= v.lo_start && cyc < v.lo_start + v.lo_len);
      check("busy_in_run", busy, 1);
      check("lda_ldb_excl", lda & ldb, 0);
      if (cyc == 1) begin
        check("load_a_lda", lda, 1);
        check("load_a_bus", bus_data, v.seed);
      end
      if (cyc == 2) begin
        check("load_b_ldb", ldb, 1);
        check("load_b_bus", bus_data, v.count);
      end
      if (decb) begin
        decbs++;
        check("emit_bus", bus_data, expv);
        check("emit_lda", lda, 1);
        if (v.lo_len == 0) check("decb_cycle", cyc, 4 + 3 * (decbs - 1));
      end
      if (out_valid) begin
        check("beat_data", out_data, expv);
        if (out_ready) begin
          beats++;
          if (v.lo_len == 0) check("beat_cycle", cyc, 5 + 3 * (beats - 1));
          last_beat = expv;
          expv = mix(expv);
        end
      end
      if (done) begin
        seen_done = 1;
        check("done_cycle", cyc, v.exp_done);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("beat_count", beats, v.exp_beats);
    check("decb_count", decbs, v.exp_beats);
    $display("run %0d seed=%h count=%0d beats=%0d decb=%0d", idx, v.seed, v.count, beats, decbs);
    start = 1'b0; seed_in = 16'h0000; count_in = 16'h0000; out_ready = 1'b1;
  endtask

  initial begin
    //            seed      count  lo_start lo_len poke done beats
    vecs[0] = '{16'h1234, 16'd0, 0, 0, 1'b0, 4,  0};
    vecs[1] = '{16'hACE1, 16'd3, 0, 0, 1'b0, 13, 3};
    vecs[2] = '{16'h5A5A, 16'd2, 5, 4, 1'b0, 14, 2};
    vecs[3] = '{16'hBEEF, 16'd2, 0, 0, 1'b1, 10, 2};
    vecs[4] = '{16'h0001, 16'd1, 0, 0, 1'b0, 7,  1};
    vecs[5] = '{16'h0F0F, 16'd1, 0, 0, 1'b0, 7,  1};

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of the first WAIT with backpressure holding the beat.
    @(negedge clk);
    start = 1'b1; seed_in = 16'h3C3C; count_in = 16'd3; out_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0; seed_in = 16'h0000; count_in = 16'h0000;
    end
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_bus", bus_data, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_strobes", {29'd0, lda, ldb, decb}, 0);
    $display("mid-run reset applied");
    @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end

    for (int i = 0; i < 6; i++) run(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/project_controller.md
# project_controller

Control FSM for the 16-bit seed/mix datapath. It drives the shared 16-bit load bus and the `lda`/`ldb`/`decb` strobes, and watches the datapath's `eq` (counter-is-zero) flag. It captures each mixed result `z` into a registered output stage and hands it downstream with a valid/ready handshake. Each result is fed back as the next seed, so a run of N produces exactly N chained samples.

## Interface
- Parameters: none (datapath width fixed at 16).
- `clk  in  1` — single clock; all state changes on rising edge.
- `rst_n  in  1` — asynchronous, active-low reset.
- `start  in  1` — run request; sampled only in IDLE.
- `seed_in  in  16` — initial seed, latched when `start` is accepted.
- `count_in  in  16` — number of samples, latched when `start` is accepted.
- `busy  out  1` — high in every state except IDLE.
- `bus_data  out  16` — drives the datapath `data_in` load bus.
- `lda  out  1` — seed-register load strobe.
- `ldb  out  1` — counter load strobe.
- `decb  out  1` — counter decrement strobe.
- `eq  in  1` — datapath counter == 0.
- `z  in  16` — datapath mixed result (combinational from the current seed).
- `out_data  out  16` — registered sample.
- `out_valid  out  1` — sample valid.
- `out_ready  in  1` — downstream accepts.
- `done  out  1` — one-cycle pulse at end of run.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CHECK, EMIT, WAIT, DONE.
- **IDLE**: `busy=0`, all strobes 0, `bus_data=0`.
  - `start=1` latches `seed_in` into `seed_q` and `count_in` into `cnt_q`, then goes to LOAD_A.
- **LOAD_A**: `bus_data=seed_q`, `lda=1`. Next state LOAD_B.
- **LOAD_B**: `bus_data=cnt_q`, `ldb=1`. Next state CHECK.
- **CHECK**: no strobes.
  - `eq=1` → DONE.
  - `eq=0` → EMIT.
- **EMIT**, for exactly one cycle:
  - `out_data<=z`, `out_valid<=1`.
  - `bus_data=z`, `lda=1`: the result is reloaded as the next seed.
  - `decb=1`.
  - Next state WAIT.
- **WAIT**: hold `out_data` and `out_valid`; all strobes 0.
  - On `out_valid & out_ready`: `out_valid<=0`, go to CHECK.
  - Otherwise stay in WAIT.
- **DONE**: `done=1` for one cycle. Next state IDLE.
- `start` is ignored whenever `busy=1`. `seed_in` and `count_in` are don't-care outside the IDLE accept cycle.
- `count_in=0`: no samples, no `decb`; `done` follows the CHECK state.
- `count_in=16'hFFFF`: 65535 samples. There is no wrap; the controller relies solely on `eq`.
- At most one of `lda`/`ldb` is high in any cycle. `decb` is high only in EMIT.
- `out_data` changes only in EMIT. It holds its last value through DONE and IDLE until the next EMIT.

## Timing
- Reset (`rst_n=0`), asynchronous and effective mid-run:
  - state=IDLE.
  - `busy=0`, `lda=0`, `ldb=0`, `decb=0`, `bus_data=0`.
  - `out_data=0`, `out_valid=0`, `done=0`.
  - `seed_q=0`, `cnt_q=0`.
  - Any in-flight sample is dropped.
- Let edge 0 be the edge that samples `start`. Then:
  - LOAD_A in cycle 1, LOAD_B in cycle 2, CHECK in cycle 3, EMIT in cycle 4.
  - First `out_valid=1` in cycle 5.
- Per-sample loop with `out_ready` held high: CHECK → EMIT → WAIT, 3 cycles.
- Each `out_ready` low cycle in WAIT adds one cycle.
- Run length with `out_ready` always high: `done` in cycle 3N+4. For N=0, `done` in cycle 4.
- `eq` is sampled only in CHECK. The counter decrement from EMIT is settled by then.
- `out_valid` never drops without a handshake. `out_ready` outside WAIT has no effect.
- `start` accepted again in the cycle after DONE (state IDLE).

## Test plan
- **Reset defaults**: assert `rst_n=0` mid-WAIT → same cycle `out_valid=0`, `busy=0`, `bus_data=0`. After release, state is IDLE and `done` never fires.
- **Zero count**: `seed=16'h1234`, `count=0`, datapath model → `lda` cycle 1 with `bus_data=16'h1234`, `ldb` cycle 2 with `bus_data=0`. No `out_valid`, no `decb`, `done` cycle 4.
- **Three samples, `out_ready=1`**: `seed=16'hACE1`, `count=3` → 3 valid beats in cycles 5, 8, 11; 3 `decb` pulses in cycles 4, 7, 10; `done` cycle 13.
  - `out_data` of each beat equals the model `z` of the previous `out_data`.
  - `bus_data` in each EMIT equals that beat's `out_data`.
- **Backpressure**: `count=2`, `out_ready` low for 4 cycles during the first WAIT → `out_data` and `out_valid` stable for those cycles, no extra `decb`, `done` delayed by exactly 4 cycles (cycle 14).
- **Start while busy**: pulse `start` with new `seed`/`count` during LOAD_B and WAIT → ignored. Run completes with the original values, and exactly one `done`.
- **Back-to-back runs**: second `start` in the cycle after `done` → accepted; `lda` in the following cycle with the new seed.
